fft_stage_ctrl: RTL and testbench
=================================

// Module: fft_stage_ctrl
// PURPOSE
//  Sequencer for the in-place radix-2 DIF FFT datapath (sample RAM -> dsp_mult butterfly -> RAM).
//  Per butterfly it generates RAM read addresses, the twiddle ROM address, the stage index and the
//  dsp_mult data_valid_i strobe. It writes results back PIPE_LAT cycles later.
//  One start_i runs all LOG2N stages back to back, then pulses done_o.
// PARAMETERS
//  LOG2N    10  log2 of transform size N (N = 2**LOG2N, range 3..12)
//  DSP_LAT  4   cycles from dsp_mult data_valid_i to data_valid_o
//  MEM_LAT  1   sample-RAM read latency in cycles
// PORTS
//  clk_i         in   1        clock, all logic on rising edge
//  rst_i         in   1        reset, asynchronous assert, active-low (0 = reset)
//  start_i       in   1        start request; sampled only in IDLE
//  busy_o        out  1        high from the cycle after start is accepted until done_o
//  done_o        out  1        one-cycle pulse after the final write-back
//  rd_en_o       out  1        sample-RAM read strobe (one butterfly issued)
//  rd_addr_a_o   out  LOG2N    upper-leg read address
//  rd_addr_b_o   out  LOG2N    lower-leg read address
//  tw_addr_o     out  LOG2N-1  twiddle ROM address, valid with rd_en_o
//  stage_o       out  SW       current stage, SW = $clog2(LOG2N)
//  bf_valid_o    out  1        to dsp_mult data_valid_i; rd_en_o delayed MEM_LAT cycles
//  dsp_valid_i   in   1        from dsp_mult data_valid_o
//  wr_en_o       out  1        write-back strobe; rd_en_o delayed PIPE_LAT = MEM_LAT+DSP_LAT
//  wr_addr_a_o   out  LOG2N    rd_addr_a_o delayed PIPE_LAT
//  wr_addr_b_o   out  LOG2N    rd_addr_b_o delayed PIPE_LAT
//  err_o         out  1        sticky: dsp_valid_i disagreed with expected wr_en_o
//  out_valid_o   out  1        bit-reversed read-out strobe (FFT_CTRL_BITREV_EN only)
//  out_addr_o    out  LOG2N    bit-reversed read-out address
// BEHAVIOUR
//  - Reset: all outputs 0. FSM returns to IDLE. Delay lines are flushed. err_o is cleared.
//    A reset mid-run aborts the run with no done_o; a later start_i restarts from stage 0.
//  - FSM: IDLE -(start_i)-> RUN -(k == N/2-1)-> DRAIN -(PIPE_LAT cycles)-> RUN with stage+1,
//    or, after the last stage -> [OUT] -> DONE -> IDLE.
//  - DONE lasts 1 cycle; done_o = 1 in DONE. start_i is ignored outside IDLE (no queueing).
//  - RUN: one butterfly per cycle, k = 0..N/2-1. Addressing for stage s:
//      span = N >> (s+1); g = k >> (LOG2N-1-s); j = k & (span-1)
//      rd_addr_a = (g << (LOG2N-s)) | j; rd_addr_b = rd_addr_a + span; tw_addr = j << s
//    All arithmetic is unsigned, modulo 2**LOG2N; no carries are kept.
//  - DRAIN: holds issue for PIPE_LAT cycles so the next stage's reads see all writes (RAW-safe).
//    Stage period = N/2 + PIPE_LAT cycles.
//  - stage_o holds its value through DRAIN. It increments on the first RUN cycle of the next stage.
//  - err_o is set when dsp_valid_i != (wr_en_o expected); it clears only on reset.
// CONFIGURATION
//  FFT_CTRL_BITREV_EN defined: after the last DRAIN, state OUT issues N cycles of
//    out_valid_o = 1, with out_addr_o = bitrev(n) for n = 0..N-1. DONE follows.
//  Not defined: the OUT state is absent; out_valid_o and out_addr_o are tied to 0.
//    DONE follows the last DRAIN directly.
// STRUCTURE
//  - Package fft_pkg: state enum (IDLE, RUN, DRAIN, OUT, DONE), the PIPE_LAT function,
//    and a bitrev function.
//  - Sub-module fft_delay_line #(W, DEPTH): shift register with async active-low reset.
//    Instantiated twice:
//      rd_en -> bf_valid (MEM_LAT)
//      {rd_en, addr_a, addr_b} -> wr_* (PIPE_LAT)
// TESTING (LOG2N=3, DSP_LAT=4, MEM_LAT=1, PIPE_LAT=5; the bench models dsp_mult as a 4-cycle delay)
//  1. start_i pulse at cycle 0 -> rd_en_o high on cycles 1..4.
//     Stage 0 addr pairs (0,4),(1,5),(2,6),(3,7); tw 0,1,2,3.
//  2. Stage 1 -> pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2. Stage 2 -> (0,1),(2,3),(4,5),(6,7), tw 0.
//     First issue of stage 1 at cycle 10.
//  3. Full run, macro off -> wr_en_o high on cycles 6..9, 15..18 and 24..27.
//     done_o = 1 only on cycle 28; busy_o high on cycles 1..28; err_o stays 0.
//  4. Drop dsp_valid_i for one cycle in stage 1 -> err_o rises the next cycle and stays 1
//    until rst_i = 0.
//  5. Assert rst_i = 0 at cycle 12, release at 14 -> all outputs 0, no done_o.
//     start_i at 20 -> stage 0 pairs again from cycle 21.
//  6. FFT_CTRL_BITREV_EN defined -> after the last drain, out_addr_o = 0,4,2,6,1,5,3,7
//     with out_valid_o high; done_o on the following cycle.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT stage sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam int MAX_LOG2N = 12;

    // Read-to-write-back distance: RAM read latency plus butterfly latency.
    function automatic int pipe_lat(input int mem_lat, input int dsp_lat);
        return mem_lat + dsp_lat;
    endfunction

    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                    input int width);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register used to align strobes and addresses with the datapath latency.
module fft_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    always_comb begin
        sr_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIF FFT sequencer: butterfly addressing, drain between stages, write-back timing.
// Optional bit-reversed read-out phase enabled by defining FFT_CTRL_BITREV_EN.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int  LOG2N   = 10,
    parameter int  DSP_LAT = 4,
    parameter int  MEM_LAT = 1,
    localparam int SW      = $clog2(LOG2N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [LOG2N-1:0] rd_addr_a_o,
    output logic [LOG2N-1:0] rd_addr_b_o,
    output logic [LOG2N-2:0] tw_addr_o,
    output logic [SW-1:0]    stage_o,
    output logic             bf_valid_o,
    input  logic             dsp_valid_i,
    output logic             wr_en_o,
    output logic [LOG2N-1:0] wr_addr_a_o,
    output logic [LOG2N-1:0] wr_addr_b_o,
    output logic             err_o,
    output logic             out_valid_o,
    output logic [LOG2N-1:0] out_addr_o
);

    localparam int            PIPE_LAT   = pipe_lat(MEM_LAT, DSP_LAT);
    localparam int            KW         = LOG2N - 1;
    localparam int            CW         = $clog2(PIPE_LAT + 1);
    localparam logic [KW-1:0] K_LAST     = '1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PIPE_LAT - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en_q, rd_en_d;
    logic             err_q, err_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic [KW-1:0]    tw_q, tw_d;
    logic             wr_en;
    logic [LOG2N-1:0] wr_a, wr_b;

`ifdef FFT_CTRL_BITREV_EN
    logic [LOG2N-1:0] n_q, n_d;
    logic             out_valid_q, out_valid_d;
    logic [LOG2N-1:0] out_addr_q, out_addr_d;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en_d = 1'b0;
`ifdef FFT_CTRL_BITREV_EN
        n_d         = n_q;
        out_valid_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    stage_d = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d     = k_q + KW'(1);
                    rd_en_d = 1'b1;
                end
            end
            // Issue is held until every write of this stage has landed in RAM.
            S_DRAIN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (stage_q != STAGE_LAST) begin
                    state_d = S_RUN;
                    stage_d = stage_q + SW'(1);
                    k_d     = '0;
                    rd_en_d = 1'b1;
`ifdef FFT_CTRL_BITREV_EN
                end else begin
                    state_d     = S_OUT;
                    n_d         = '0;
                    out_valid_d = 1'b1;
                end
            end
            S_OUT: begin
                if (n_q == '1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    n_d         = n_q + LOG2N'(1);
                    out_valid_d = 1'b1;
                end
            end
`else
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        err_d = err_q | (dsp_valid_i != wr_en);
`ifdef FFT_CTRL_BITREV_EN
        out_addr_d = out_valid_d ? LOG2N'(bitrev(MAX_LOG2N'(n_d), LOG2N)) : '0;
`endif
    end

    // Butterfly addressing for the next issue; idle cycles present zero addresses.
    always_comb begin
        logic [LOG2N-1:0] k_ext, span, grp, j, a;
        k_ext    = {1'b0, k_d};
        span     = LOG2N'(1) << (KW - int'(stage_d));
        grp      = k_ext >> (KW - int'(stage_d));
        j        = k_ext & (span - LOG2N'(1));
        a        = (grp << (LOG2N - int'(stage_d))) | j;
        addr_a_d = rd_en_d ? a : '0;
        addr_b_d = rd_en_d ? (a + span) : '0;
        tw_d     = rd_en_d ? KW'(j << stage_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            err_q    <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            err_q    <= err_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

`ifdef FFT_CTRL_BITREV_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            n_q         <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
`else
    assign out_valid_o = 1'b0;
    assign out_addr_o  = '0;
`endif

    fft_delay_line #(.W(1), .DEPTH(MEM_LAT)) u_bf_dly (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .d_i    (rd_en_q),
        .q_o    (bf_valid_o)
    );

    fft_delay_line #(.W(1 + 2*LOG2N), .DEPTH(PIPE_LAT)) u_wr_dly (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .d_i    ({rd_en_q, addr_a_q, addr_b_q}),
        .q_o    ({wr_en, wr_a, wr_b})
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = addr_a_q;
    assign rd_addr_b_o = addr_b_q;
    assign tw_addr_o   = tw_q;
    assign stage_o     = stage_q;
    assign wr_en_o     = wr_en;
    assign wr_addr_a_o = wr_a;
    assign wr_addr_b_o = wr_b;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl at N=8 with a 4-cycle dsp_mult model.
`timescale 1ns/1ps
module tb_fft_stage_ctrl;

    localparam int LOG2N   = 3;
    localparam int DSP_LAT = 4;
    localparam int MEM_LAT = 1;
    localparam int N       = 8;
    localparam int HALF    = 4;
    localparam int PL      = 5;
    localparam int PERIOD  = HALF + PL;
    localparam int RUN_END = LOG2N * PERIOD;
`ifdef FFT_CTRL_BITREV_EN
    localparam int OUTN = N;
`else
    localparam int OUTN = 0;
`endif
    localparam int LAST = RUN_END + 1 + OUTN;

    logic       clk, rst_i, start_i, dsp_valid_i, drop;
    logic       busy_o, done_o, rd_en_o, bf_valid_o, wr_en_o, err_o, out_valid_o;
    logic [2:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o, out_addr_o;
    logic [1:0] tw_addr_o, stage_o;
    logic [DSP_LAT-1:0] dsp_sr;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic [1:0] s;
    } iss_t;

    iss_t rd_q[$];
    iss_t wr_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    fft_stage_ctrl #(.LOG2N(LOG2N), .DSP_LAT(DSP_LAT), .MEM_LAT(MEM_LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_a_o (rd_addr_a_o),
        .rd_addr_b_o (rd_addr_b_o),
        .tw_addr_o   (tw_addr_o),
        .stage_o     (stage_o),
        .bf_valid_o  (bf_valid_o),
        .dsp_valid_i (dsp_valid_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_a_o (wr_addr_a_o),
        .wr_addr_b_o (wr_addr_b_o),
        .err_o       (err_o),
        .out_valid_o (out_valid_o),
        .out_addr_o  (out_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dsp_mult stand-in: a DSP_LAT-cycle delay of bf_valid_o, reset together with the controller.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) dsp_sr <= '0;
        else        dsp_sr <= {dsp_sr[DSP_LAT-2:0], bf_valid_o};
    end
    assign dsp_valid_i = dsp_sr[DSP_LAT-1] & ~drop;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit issue_at(input int u);
        return (u >= 1) && (u <= RUN_END) && (((u - 1) % PERIOD) < HALF);
    endfunction

    function automatic logic [2:0] brev3(input int n);
        logic [2:0] v;
        v = 3'(n);
        return {v[0], v[1], v[2]};
    endfunction

    // Expected {rd_en, bf_valid, wr_en, done, busy, err, out_valid, out_addr} at cycle u after start.
    function automatic logic [9:0] model_ctl(input int u, input int drop_t);
        logic rd, bf, wr, dn, by, er, ov;
        logic [2:0] oa;
        rd = issue_at(u);
        bf = issue_at(u - MEM_LAT);
        wr = issue_at(u - PL);
        dn = (u == LAST);
        by = (u >= 1) && (u <= LAST);
        er = (drop_t > 0) && (u > drop_t);
        ov = (u > RUN_END) && (u <= RUN_END + OUTN);
        oa = ov ? brev3(u - RUN_END - 1) : 3'd0;
        return {rd, bf, wr, dn, by, er, ov, oa};
    endfunction

    // Classic nested-loop DIF enumeration: group-major, offset-minor.
    task automatic push_run();
        iss_t e;
        for (int s = 0; s < LOG2N; s++) begin
            int span;
            span = N >> (s + 1);
            for (int g = 0; g < N; g += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    e.a  = 3'(g + j);
                    e.b  = 3'(g + j + span);
                    e.tw = 2'(j << s);
                    e.s  = 2'(s);
                    rd_q.push_back(e);
                    wr_q.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [25:0] all_o;
        rst_i   = 1'b0;
        start_i = 1'b0;
        drop    = 1'b0;
        step();
        step();
        all_o = {busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o, bf_valid_o,
                 wr_en_o, wr_addr_a_o, wr_addr_b_o, err_o, out_valid_o, out_addr_o};
        vectors++;
        if (all_o !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_hold outputs got %h want 0", all_o);
        end
        rst_i = 1'b1;
        step();
        all_o = {busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o, bf_valid_o,
                 wr_en_o, wr_addr_a_o, wr_addr_b_o, err_o, out_valid_o, out_addr_o};
        vectors++;
        if (all_o !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_release outputs got %h want 0", all_o);
        end
    endtask

    task automatic test_run(input string name, input bit noise, input int drop_t);
        logic [9:0] exp_c, act_c;
        iss_t e;
        step();
        start_i = 1'b1;
        push_run();
        for (int t = 0; t <= LAST + 2; t++) begin
            if (t > 0) step();
            if (t == 1) start_i = 1'b0;
            if (noise && t == 7) start_i = 1'b1;
            if (noise && t == 8) start_i = 1'b0;
            drop = (drop_t > 0) && (t == drop_t);
            exp_c = model_ctl(t, drop_t);
            act_c = {rd_en_o, bf_valid_o, wr_en_o, done_o, busy_o, err_o, out_valid_o, out_addr_o};
            vectors++;
            if (act_c !== exp_c) begin
                miscompares++;
                $display("FAIL %s_ctl t=%0d got %b want %b", name, t, act_c, exp_c);
            end
            if (rd_en_o) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_rd t=%0d got unexpected issue want none", name, t);
                end else begin
                    e = rd_q.pop_front();
                    if ({rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o} !== e) begin
                        miscompares++;
                        $display("FAIL %s_rd t=%0d got a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                                 name, t, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o, e.a, e.b, e.tw, e.s);
                    end
                end
            end
            if (wr_en_o) begin
                vectors++;
                if (wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_wr t=%0d got unexpected write want none", name, t);
                end else begin
                    e = wr_q.pop_front();
                    if ({wr_addr_a_o, wr_addr_b_o} !== {e.a, e.b}) begin
                        miscompares++;
                        $display("FAIL %s_wr t=%0d got a=%0d b=%0d want a=%0d b=%0d",
                                 name, t, wr_addr_a_o, wr_addr_b_o, e.a, e.b);
                    end
                end
            end
        end
        drop = 1'b0;
        vectors++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_leftover got rd=%0d wr=%0d pending want 0", name, rd_q.size(), wr_q.size());
            rd_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic test_full_run();
        test_run("full", 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        test_run("busy_start", 1'b1, 0);
    endtask

    task automatic test_err_sticky();
        test_run("err", 1'b0, 16);
        vectors++;
        if (err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL err_idle_hold got %b want 1", err_o);
        end
        rst_i = 1'b0;
        #1;
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_reset_clear got %b want 0", err_o);
        end
        step();
        rst_i = 1'b1;
        step();
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_after_release got %b want 0", err_o);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0]  exp_c, act_c;
        logic [25:0] all_o;
        iss_t e;
        step();
        start_i = 1'b1;
        push_run();
        for (int t = 0; t <= 20 + LAST + 2; t++) begin
            if (t > 0) step();
            if (t == 1 || t == 21) start_i = 1'b0;
            if (t == 12) begin
                rst_i = 1'b0;
                #1;
                rd_q.delete();
                wr_q.delete();
            end
            if (t == 14) rst_i = 1'b1;
            if (t == 20) begin
                start_i = 1'b1;
                push_run();
            end
            if (t >= 12 && t <= 20) begin
                all_o = {busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o, bf_valid_o,
                         wr_en_o, wr_addr_a_o, wr_addr_b_o, err_o, out_valid_o, out_addr_o};
                vectors++;
                if (all_o !== 26'd0) begin
                    miscompares++;
                    $display("FAIL abort_zero t=%0d got %h want 0", t, all_o);
                end
            end else begin
                exp_c = model_ctl((t < 12) ? t : t - 20, 0);
                act_c = {rd_en_o, bf_valid_o, wr_en_o, done_o, busy_o, err_o, out_valid_o, out_addr_o};
                vectors++;
                if (act_c !== exp_c) begin
                    miscompares++;
                    $display("FAIL abort_ctl t=%0d got %b want %b", t, act_c, exp_c);
                end
                if (rd_en_o) begin
                    vectors++;
                    if (rd_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL abort_rd t=%0d got unexpected issue want none", t);
                    end else begin
                        e = rd_q.pop_front();
                        if ({rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o} !== e) begin
                            miscompares++;
                            $display("FAIL abort_rd t=%0d got a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                                     t, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o, e.a, e.b, e.tw, e.s);
                        end
                    end
                end
                if (wr_en_o) begin
                    vectors++;
                    if (wr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL abort_wr t=%0d got unexpected write want none", t);
                    end else begin
                        e = wr_q.pop_front();
                        if ({wr_addr_a_o, wr_addr_b_o} !== {e.a, e.b}) begin
                            miscompares++;
                            $display("FAIL abort_wr t=%0d got a=%0d b=%0d want a=%0d b=%0d",
                                     t, wr_addr_a_o, wr_addr_b_o, e.a, e.b);
                        end
                    end
                end
            end
        end
        vectors++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_leftover got rd=%0d wr=%0d pending want 0", rd_q.size(), wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_ignored();
        test_err_sticky();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
